// File: rtl/rob_param.sv
// Parametrised reorder buffer: in-order alloc/retire, dual writeback, dual operand lookup, one-cycle flush.
// Optional same-cycle writeback bypass on lookups is enabled by defining ROB_BYPASS_EN.
module rob_param #(
  parameter int DEPTH = 16,
  parameter int IDX_W = 4,
  parameter int XLEN  = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             rdy,
  input  logic             alloc_valid,
  input  logic [2:0]       alloc_kind,
  input  logic [4:0]       alloc_rd,
  input  logic             alloc_ready,
  input  logic [XLEN-1:0]  alloc_val,
  input  logic             alloc_pred_taken,
  output logic [IDX_W-1:0] alloc_idx,
  output logic             rob_full,
  input  logic [IDX_W-1:0] q1_idx,
  input  logic [IDX_W-1:0] q2_idx,
  output logic             q1_ready,
  output logic             q2_ready,
  output logic [XLEN-1:0]  q1_val,
  output logic [XLEN-1:0]  q2_val,
  input  logic             wb_valid,
  input  logic [IDX_W-1:0] wb_idx,
  input  logic [XLEN-1:0]  wb_val,
  input  logic             ld_valid,
  input  logic [IDX_W-1:0] ld_idx,
  input  logic [XLEN-1:0]  ld_val,
  output logic             commit_we,
  output logic [IDX_W-1:0] commit_idx,
  output logic [4:0]       commit_rd,
  output logic [XLEN-1:0]  commit_val,
  output logic             store_commit,
  output logic             flush,
  output logic [XLEN-1:0]  flush_pc
);

  typedef enum logic [2:0] {
    K_ALU    = 3'd0,
    K_LOAD   = 3'd1,
    K_STORE  = 3'd2,
    K_BRANCH = 3'd3,
    K_JALR   = 3'd4
  } kind_t;

  localparam logic [IDX_W:0] FULL_CNT = (IDX_W+1)'(DEPTH);

  logic [IDX_W-1:0] head, tail;
  logic [IDX_W:0]   count;
  logic [DEPTH-1:0] busy, ready, pred, mispred;
  logic [2:0]       kind   [DEPTH];
  logic [4:0]       rd     [DEPTH];
  logic [XLEN-1:0]  val    [DEPTH];
  logic [XLEN-1:0]  target [DEPTH];

  logic             live, alloc_ok, retire, redirect;
  logic [2:0]       kind_h;
  logic [DEPTH-1:0] wr_en;
  logic [XLEN-1:0]  wr_dat [DEPTH];

  assign live      = rdy && !flush;
  assign rob_full  = (count == FULL_CNT);
  assign alloc_idx = tail;
  assign alloc_ok  = alloc_valid && !rob_full && live;

  assign kind_h       = kind[head];
  assign retire       = busy[head] && ready[head] && live;
  assign commit_idx   = head;
  assign commit_rd    = rd[head];
  assign commit_val   = val[head];
  assign commit_we    = retire && (kind_h == K_ALU || kind_h == K_LOAD || kind_h == K_JALR)
                        && (rd[head] != 5'd0);
  assign store_commit = retire && (kind_h == K_STORE);
  assign redirect     = retire && ((kind_h == K_BRANCH && mispred[head]) || kind_h == K_JALR);

  // Per-entry write port; the retiring head is frozen, and exec overrides load on the same index.
  always_comb begin
    for (int i = 0; i < DEPTH; i++) begin
      wr_en[i]  = 1'b0;
      wr_dat[i] = ld_val;
      if (live && busy[i] && !(retire && head == IDX_W'(i))) begin
        if (ld_valid && ld_idx == IDX_W'(i)) wr_en[i] = 1'b1;
        if (wb_valid && wb_idx == IDX_W'(i)) begin
          wr_en[i]  = 1'b1;
          wr_dat[i] = wb_val;
        end
      end
    end
  end

  always_comb begin
    q1_ready = busy[q1_idx] && ready[q1_idx];
    q1_val   = val[q1_idx];
    q2_ready = busy[q2_idx] && ready[q2_idx];
    q2_val   = val[q2_idx];
`ifdef ROB_BYPASS_EN
    // Branch results never land in val, so they are not forwarded.
    if (wr_en[q1_idx] && kind[q1_idx] != K_BRANCH) begin
      q1_ready = 1'b1;
      q1_val   = wr_dat[q1_idx];
    end
    if (wr_en[q2_idx] && kind[q2_idx] != K_BRANCH) begin
      q2_ready = 1'b1;
      q2_val   = wr_dat[q2_idx];
    end
`endif
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      head     <= '0;
      tail     <= '0;
      count    <= '0;
      busy     <= '0;
      ready    <= '0;
      flush    <= 1'b0;
      flush_pc <= '0;
    end else if (rdy) begin
      if (flush) begin
        head  <= '0;
        tail  <= '0;
        count <= '0;
        busy  <= '0;
        ready <= '0;
        flush <= 1'b0;
      end else begin
        for (int i = 0; i < DEPTH; i++) begin
          if (wr_en[i]) begin
            ready[i] <= 1'b1;
            case (kind[i])
              K_BRANCH: mispred[i] <= (wr_dat[i][0] != pred[i]);
              K_JALR:   target[i]  <= wr_dat[i];
              default:  val[i]     <= wr_dat[i];
            endcase
          end
        end

        if (retire) begin
          busy[head] <= 1'b0;
          head       <= head + 1'b1;
        end

        if (redirect) begin
          flush    <= 1'b1;
          flush_pc <= (kind_h == K_BRANCH) ? val[head] : target[head];
        end

        if (alloc_ok) begin
          busy[tail]    <= 1'b1;
          ready[tail]   <= alloc_ready || (alloc_kind == K_STORE);
          kind[tail]    <= alloc_kind;
          rd[tail]      <= alloc_rd;
          val[tail]     <= alloc_val;
          pred[tail]    <= alloc_pred_taken;
          mispred[tail] <= 1'b0;
          target[tail]  <= '0;
          tail          <= tail + 1'b1;
        end

        case ({alloc_ok, retire})
          2'b10:   count <= count + 1'b1;
          2'b01:   count <= count - 1'b1;
          default: count <= count;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_rob_param.sv
// Bench for rob_param: directed scenarios with literal expectations, then randomized traffic
// checked every cycle against a queue-based model of the in-flight instructions.
module tb_rob_param;
  localparam int D = 16;
  localparam int IW = 4;
  localparam int XL = 32;

  logic clk = 1'b0;
  logic rst, rdy;
  logic alloc_valid, alloc_ready, alloc_pred_taken;
  logic [2:0] alloc_kind;
  logic [4:0] alloc_rd;
  logic [XL-1:0] alloc_val;
  logic [IW-1:0] alloc_idx, q1_idx, q2_idx, wb_idx, ld_idx, commit_idx;
  logic rob_full, q1_ready, q2_ready, wb_valid, ld_valid;
  logic [XL-1:0] q1_val, q2_val, wb_val, ld_val, commit_val, flush_pc;
  logic commit_we, store_commit, flush;
  logic [4:0] commit_rd;

  always #5 clk = ~clk;

  rob_param #(.DEPTH(D), .IDX_W(IW), .XLEN(XL)) dut (
    .clk(clk), .rst(rst), .rdy(rdy),
    .alloc_valid(alloc_valid), .alloc_kind(alloc_kind), .alloc_rd(alloc_rd),
    .alloc_ready(alloc_ready), .alloc_val(alloc_val), .alloc_pred_taken(alloc_pred_taken),
    .alloc_idx(alloc_idx), .rob_full(rob_full),
    .q1_idx(q1_idx), .q2_idx(q2_idx), .q1_ready(q1_ready), .q2_ready(q2_ready),
    .q1_val(q1_val), .q2_val(q2_val),
    .wb_valid(wb_valid), .wb_idx(wb_idx), .wb_val(wb_val),
    .ld_valid(ld_valid), .ld_idx(ld_idx), .ld_val(ld_val),
    .commit_we(commit_we), .commit_idx(commit_idx), .commit_rd(commit_rd),
    .commit_val(commit_val), .store_commit(store_commit),
    .flush(flush), .flush_pc(flush_pc)
  );

  // Model: in-flight instructions in program order; q[0] is the oldest (at index mhead).
  typedef struct {
    int idx;
    int kind;
    int rd;
    bit done;
    logic [XL-1:0] val;
    bit pred;
    bit mis;
    logic [XL-1:0] tgt;
  } ent_t;

  ent_t q[$];
  int mhead;
  bit mflush;
  logic [XL-1:0] mflush_pc;

  int n_chk = 0;
  int n_pass = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
  endtask

  function automatic int find(input int idx);
    for (int p = 0; p < q.size(); p++)
      if (q[p].idx == idx) return p;
    return -1;
  endfunction

  function automatic bit retiring();
    return rdy && !mflush && q.size() > 0 && q[0].done;
  endfunction

  task automatic chk_lookup(input string name, input int idx, input logic r_act, input logic [XL-1:0] v_act);
    int p;
    bit r;
    logic [XL-1:0] v;
    p = find(idx);
    r = (p >= 0) && q[p].done;
    v = (p >= 0) ? q[p].val : '0;
`ifdef ROB_BYPASS_EN
    if (p >= 0 && rdy && !mflush && q[p].kind != 3 && !(retiring() && p == 0)) begin
      if (wb_valid && wb_idx == IW'(idx)) begin r = 1; v = wb_val; end
      else if (ld_valid && ld_idx == IW'(idx)) begin r = 1; v = ld_val; end
    end
`endif
    chk({name, "_ready"}, r_act, r);
    if (r) chk({name, "_val"}, v_act, v);
  endtask

  task automatic settle();
    int n, k;
    bit ret;
    #1;
    n = q.size();
    ret = retiring();
    k = (n > 0) ? q[0].kind : 0;
    chk("rob_full", rob_full, n == D);
    chk("alloc_idx", alloc_idx, (mhead + n) % D);
    chk("commit_idx", commit_idx, mhead);
    chk("commit_we", commit_we, ret && (k == 0 || k == 1 || k == 4) && q[0].rd != 0);
    chk("store_commit", store_commit, ret && k == 2);
    if (ret) begin
      chk("commit_rd", commit_rd, q[0].rd);
      chk("commit_val", commit_val, q[0].val);
    end
    chk("flush", flush, mflush);
    chk("flush_pc", flush_pc, mflush_pc);
    chk_lookup("q1", int'(q1_idx), q1_ready, q1_val);
    chk_lookup("q2", int'(q2_idx), q2_ready, q2_val);
  endtask

  task automatic apply_wb(input int idx, input logic [XL-1:0] d, input bit ret);
    int p;
    p = find(idx);
    if (p < 0 || (ret && p == 0)) return;
    q[p].done = 1;
    if (q[p].kind == 3) q[p].mis = (d[0] != q[p].pred);
    else if (q[p].kind == 4) q[p].tgt = d;
    else q[p].val = d;
  endtask

  task automatic model_step();
    int n, tail;
    bit full, ret;
    ent_t e;
    if (rst) begin
      q.delete(); mhead = 0; mflush = 0; mflush_pc = '0;
      return;
    end
    if (!rdy) return;
    if (mflush) begin
      q.delete(); mhead = 0; mflush = 0;
      return;
    end
    n = q.size();
    full = (n == D);
    tail = (mhead + n) % D;
    ret = retiring();
    if (ld_valid) apply_wb(int'(ld_idx), ld_val, ret);
    if (wb_valid) apply_wb(int'(wb_idx), wb_val, ret);
    if (ret) begin
      e = q.pop_front();
      mhead = (mhead + 1) % D;
      if ((e.kind == 3 && e.mis) || e.kind == 4) begin
        mflush = 1;
        mflush_pc = (e.kind == 3) ? e.val : e.tgt;
      end
    end
    if (alloc_valid && !full) begin
      e.idx = tail; e.kind = int'(alloc_kind); e.rd = int'(alloc_rd);
      e.done = alloc_ready || alloc_kind == 3'd2; e.val = alloc_val;
      e.pred = alloc_pred_taken; e.mis = 0; e.tgt = '0;
      q.push_back(e);
    end
  endtask

  task automatic advance();
    model_step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic idle();
    rst = 0; rdy = 1;
    alloc_valid = 0; alloc_kind = 0; alloc_rd = 0; alloc_ready = 0; alloc_val = 0; alloc_pred_taken = 0;
    wb_valid = 0; wb_idx = 0; wb_val = 0; ld_valid = 0; ld_idx = 0; ld_val = 0;
    q1_idx = 0; q2_idx = 0;
  endtask

  task automatic alloc(input int k, input int r, input bit rd_y, input logic [XL-1:0] v, input bit p);
    alloc_valid = 1; alloc_kind = 3'(k); alloc_rd = 5'(r);
    alloc_ready = rd_y; alloc_val = v; alloc_pred_taken = p;
  endtask

  task automatic do_reset();
    idle();
    rst = 1;
    model_step();
    @(posedge clk);
    @(negedge clk);
    rst = 0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    @(negedge clk);
    do_reset();

    // Reset state
    idle(); settle();
    chk("rst_full", rob_full, 0);
    chk("rst_alloc_idx", alloc_idx, 0);
    chk("rst_commit_we", commit_we, 0);
    chk("rst_flush", flush, 0);
    chk("rst_flush_pc", flush_pc, 0);

    // Fill all 16 entries; a 17th alloc is dropped
    for (int i = 0; i < D; i++) begin
      idle(); alloc(0, 1, 0, 32'(i), 0); settle(); advance();
    end
    idle(); alloc(0, 1, 0, 32'h99, 0); settle();
    chk("full_after16", rob_full, 1);
    chk("full_tail", alloc_idx, 0);
    advance();
    idle(); settle();
    chk("full_after17", rob_full, 1);
    chk("full_tail17", alloc_idx, 0);

    // ALU writeback then commit
    do_reset();
    idle(); alloc(0, 5, 0, 0, 0); settle(); advance();
    idle(); wb_valid = 1; wb_idx = 0; wb_val = 32'h1234; settle();
    chk("alu_no_early_commit", commit_we, 0);
    advance();
    idle(); settle();
    chk("alu_commit_we", commit_we, 1);
    chk("alu_commit_rd", commit_rd, 5);
    chk("alu_commit_val", commit_val, 32'h1234);
    advance();
    idle(); settle();
    chk("alu_head", commit_idx, 1);

    // Mispredicted branch flushes the younger ALU
    do_reset();
    idle(); alloc(3, 0, 0, 32'h80, 1); settle(); advance();
    idle(); alloc(0, 3, 1, 32'h55, 0); settle(); advance();
    idle(); wb_valid = 1; wb_idx = 0; wb_val = 0; settle(); advance();
    idle(); settle();
    chk("br_retire_we", commit_we, 0);
    advance();
    idle(); settle();
    chk("br_flush", flush, 1);
    chk("br_flush_pc", flush_pc, 32'h80);
    chk("br_younger_blocked", commit_we, 0);
    advance();
    idle(); settle();
    chk("br_after_flush", flush, 0);
    chk("br_empty_tail", alloc_idx, 0);
    chk("br_empty_we", commit_we, 0);

    // JALR commits its link value then redirects to the target
    do_reset();
    idle(); alloc(4, 1, 0, 32'h104, 0); settle(); advance();
    idle(); wb_valid = 1; wb_idx = 0; wb_val = 32'h2000; settle(); advance();
    idle(); settle();
    chk("jalr_we", commit_we, 1);
    chk("jalr_link", commit_val, 32'h104);
    advance();
    idle(); settle();
    chk("jalr_flush", flush, 1);
    chk("jalr_flush_pc", flush_pc, 32'h2000);
    advance();

    // Store retires without writeback; ALU to x0 does not write
    do_reset();
    idle(); alloc(2, 0, 0, 0, 0); settle(); advance();
    idle(); alloc(0, 0, 1, 32'h9, 0); settle();
    chk("st_commit", store_commit, 1);
    chk("st_head", commit_idx, 0);
    advance();
    idle(); settle();
    chk("x0_we", commit_we, 0);
    chk("x0_head", commit_idx, 1);
    advance();

    // Lookup against a same-cycle writeback
    do_reset();
    for (int i = 0; i < 4; i++) begin
      idle(); alloc(0, 2, 0, 0, 0); settle(); advance();
    end
    idle(); q1_idx = 3; wb_valid = 1; wb_idx = 3; wb_val = 32'h7; settle();
`ifdef ROB_BYPASS_EN
    chk("byp_q1_ready", q1_ready, 1);
    chk("byp_q1_val", q1_val, 32'h7);
`else
    chk("byp_q1_ready", q1_ready, 0);
`endif
    advance();
    idle(); q1_idx = 3; settle();
    chk("byp_next_ready", q1_ready, 1);
    chk("byp_next_val", q1_val, 32'h7);
    advance();

    // Randomized traffic
    do_reset();
    for (int c = 0; c < 4000; c++) begin
      int r, n;
      idle();
      n = q.size();
      rst = ($urandom_range(0, 399) == 0);
      rdy = ($urandom_range(0, 9) != 0);
      if ($urandom_range(0, 9) < 6) begin
        r = $urandom_range(0, 9);
        alloc((r < 5 || r == 9) ? 0 : r - 4, $urandom_range(0, 31), $urandom_range(0, 9) < 3,
              $urandom, $urandom_range(0, 1));
      end
      wb_valid = $urandom_range(0, 1);
      wb_idx = IW'((n > 0 && $urandom_range(0, 3) != 0) ? mhead + $urandom_range(0, n - 1) : $urandom);
      wb_val = $urandom;
      ld_valid = $urandom_range(0, 1);
      ld_idx = ($urandom_range(0, 3) == 0) ? wb_idx
             : IW'((n > 0) ? mhead + $urandom_range(0, n - 1) : $urandom);
      ld_val = $urandom;
      q1_idx = ($urandom_range(0, 1) == 0) ? wb_idx : IW'($urandom);
      q2_idx = ($urandom_range(0, 1) == 0) ? ld_idx : IW'($urandom);
      settle();
      advance();
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
